// File: rtl/iterative_alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes from the ALU
// control decoder and the two-state sequencing encoding.
package iterative_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_MUL = 3'b011,
        OP_SUB = 3'b110
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// Request/result bundle between the decode/hazard logic and the execute ALU.
interface iterative_alu_if #(
    parameter int WIDTH = 32
) ();

    logic             valid_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             busy_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i,
        input  data_o, valid_o, busy_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i,
        output data_o, valid_o, busy_o
    );

endinterface

// File: rtl/iterative_alu_shift_add_mul.sv
// Radix-2 shift-add multiplier: WIDTH iterations, low WIDTH product bits only,
// so the result is identical for signed and unsigned operands.
module iterative_alu_shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // The final iteration's sum is handed out directly so the top can register
    // it on the same edge that retires the last step.
    assign o_done    = i_step && (r_cnt == LAST_CNT);
    assign o_product = w_acc_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/iterative_alu.sv
// Execute-stage ALU: AND/OR/ADD/SUB retire in one cycle, MUL iterates for
// WIDTH cycles while busy_o stalls the upstream pipeline.
module iterative_alu
    import iterative_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    iterative_alu_if.slave bus
);

    alu_state_e       r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic             w_accept;
    logic             w_start;
    logic             w_step;
    logic             w_done;
    logic [WIDTH-1:0] w_product;
    logic [WIDTH-1:0] w_single;

    assign bus.data_o  = r_data;
    assign bus.valid_o = r_valid;
    assign bus.busy_o  = (r_state == ST_MUL);

    // Requests arriving while a MUL runs are dropped, not queued.
    assign w_accept = bus.valid_i && (r_state == ST_IDLE);
    assign w_start  = w_accept && is_mul(bus.ALUCtrl_i);
    assign w_step   = (r_state == ST_MUL);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_single = bus.data1_i + bus.data2_i;
        case (bus.ALUCtrl_i)
            OP_AND:  w_single = bus.data1_i & bus.data2_i;
            OP_OR:   w_single = bus.data1_i | bus.data2_i;
            OP_SUB:  w_single = bus.data1_i - bus.data2_i;
            default: w_single = bus.data1_i + bus.data2_i;
        endcase
    end

    iterative_alu_shift_add_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_start  (w_start),
        .i_step   (w_step),
        .i_mcand  (bus.data1_i),
        .i_mplier (bus.data2_i),
        .o_done   (w_done),
        .o_product(w_product)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_MUL;
                    end else if (w_accept) begin
                        r_data  <= w_single;
                        r_valid <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (w_done) begin
                        r_data  <= w_product;
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
